// File: rtl/keyboard_tx.sv
// keyboard_tx
// ---------------------------------------------------------------------------
// Serial keyboard emulator. The 4-bit key code on sw4..sw1 is mapped to its
// ASCII hex character ('0'-'9', 'A'-'F') and sent on an 8N1 line, LSB first,
// once per press of btn_write or repeatedly while btn_auto is held.
//
// Ports (top module keyboard_tx):
//   sysclk     in   system clock, all logic on the rising edge
//   rst        in   asynchronous active-high reset
//   sw1..sw4   in   key code bits 0..3 (sw4 is the MSB)
//   btn_write  in   single-shot send button (async, bouncy)
//   btn_auto   in   auto-repeat button (async, bouncy)
//   out        out  serial data line, idle high
//
// Helper module keyboard_tx_debounce:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   level_i       synchronized raw button level
//   level_o       accepted (debounced) level
// ---------------------------------------------------------------------------

module keyboard_tx_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic level_o
);

    localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    // The counter only runs while the input disagrees with the accepted
    // level, so any glitch back to the accepted level restarts the wait.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (level_i != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = level_i;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

module keyboard_tx #(
    parameter int BAUD_DIV        = 5208,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int AUTO_PERIOD     = 250000
) (
    input  logic sysclk,
    input  logic rst,
    input  logic sw1,
    input  logic sw2,
    input  logic sw3,
    input  logic sw4,
    input  logic btn_write,
    input  logic btn_auto,
    output logic out
);

    localparam int BaudW = $clog2(BAUD_DIV + 1);
    localparam int AutoW = $clog2(AUTO_PERIOD + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_e;

    // Bit layout of the synchronizer: [3:0] key code, [4] write, [5] auto.
    logic [5:0] sync1_q, sync2_q;

    logic writeDeb, autoDeb;
    logic writePrev_q, autoPrev_q;
    logic [AutoW-1:0] autoCnt_q, autoCnt_d;
    logic writeReq, autoReq, request;

    txState_e         state_q, state_d;
    logic [BaudW-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       char_q, char_d;
    logic             pending_q, pending_d;
    logic             baudDone;

    function automatic logic [7:0] hexChar(input logic [3:0] code);
        if (code < 4'd10) begin
            return 8'h30 + {4'h0, code};
        end
        return 8'h37 + {4'h0, code};
    endfunction

    // Two-stage synchronizer for all six asynchronous board inputs.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_auto, btn_write, sw4, sw3, sw2, sw1};
            sync2_q <= sync1_q;
        end
    end

    keyboard_tx_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debWrite (
        .clk_i  (sysclk),
        .rst_i  (rst),
        .level_i(sync2_q[4]),
        .level_o(writeDeb)
    );

    keyboard_tx_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debAuto (
        .clk_i  (sysclk),
        .rst_i  (rst),
        .level_i(sync2_q[5]),
        .level_o(autoDeb)
    );

    // Rising-edge detection on the debounced buttons; auto also fires each
    // time its period counter wraps, and the counter restarts on every pulse
    // so the period is measured from the previous request.
    assign writeReq = writeDeb & ~writePrev_q;
    assign autoReq  = (autoDeb & ~autoPrev_q) |
                      (autoDeb & (autoCnt_q == AutoW'(AUTO_PERIOD - 1)));
    assign request  = writeReq | autoReq;

    always_comb begin
        autoCnt_d = autoCnt_q + AutoW'(1);
        if (!autoDeb || autoReq) begin
            autoCnt_d = '0;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            writePrev_q <= 1'b0;
            autoPrev_q  <= 1'b0;
            autoCnt_q   <= '0;
        end else begin
            writePrev_q <= writeDeb;
            autoPrev_q  <= autoDeb;
            autoCnt_q   <= autoCnt_d;
        end
    end

    // Transmitter state register.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            char_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            char_q    <= char_d;
            pending_q <= pending_d;
        end
    end

    assign baudDone = (baudCnt_q == BaudW'(BAUD_DIV - 1));

    // Next-state logic. In IDLE a request arriving this cycle is taken
    // directly, so the start bit follows the request by one cycle; during a
    // frame requests fold into the single pending flag.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        char_d    = char_q;
        pending_d = pending_q | request;
        case (state_q)
            IDLE: begin
                if (pending_q || request) begin
                    char_d    = hexChar(sync2_q[3:0]);
                    pending_d = 1'b0;
                    baudCnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baudDone) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q + BaudW'(1);
                end
            end
            DATA: begin
                if (baudDone) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + BaudW'(1);
                end
            end
            STOP: begin
                if (baudDone) begin
                    baudCnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    baudCnt_d = baudCnt_q + BaudW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line driver decoded straight from the state, so the asynchronous reset
    // forces the line high immediately.
    always_comb begin
        out = 1'b1;
        case (state_q)
            START:   out = 1'b0;
            DATA:    out = char_q[bitIdx_q];
            default: out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_keyboard_tx.sv
// tb_keyboard_tx
// ---------------------------------------------------------------------------
// Testbench for keyboard_tx with BAUD_DIV=4, DEBOUNCE_CYCLES=8,
// AUTO_PERIOD=60. A behavioural model predicts the serial line on every
// cycle from the raw button/switch history, and a small UART receiver
// decodes the line so each scenario can be pinned with literal frame
// contents and start offsets.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_keyboard_tx;

    localparam int BAUD_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int AUTO_PERIOD     = 60;
    localparam int FRAME           = 10 * BAUD_DIV;
    localparam int HIST            = 8192;

    logic sysclk = 1'b0;
    logic rst;
    logic sw1, sw2, sw3, sw4;
    logic btnWrite, btnAuto;
    logic out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    keyboard_tx #(
        .BAUD_DIV       (BAUD_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .AUTO_PERIOD    (AUTO_PERIOD)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .sw1      (sw1),
        .sw2      (sw2),
        .sw3      (sw3),
        .sw4      (sw4),
        .btn_write(btnWrite),
        .btn_auto (btnAuto),
        .out      (out)
    );

    always #10 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive all inputs just after a rising edge and hold them for n cycles.
    task automatic applyStimulus(input logic w, input logic a, input logic [3:0] code, input int n);
        {sw4, sw3, sw2, sw1} = code;
        btnWrite = w;
        btnAuto  = a;
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       rawW [HIST];
    logic       rawA [HIST];
    logic [3:0] rawSw[HIST];

    logic       mWriteDeb = 1'b0;
    logic       mAutoDeb  = 1'b0;
    int         mAutoLast = 0;
    logic       mInFrame  = 1'b0;
    int         mStart    = 0;
    logic [7:0] mChar     = 8'h00;
    logic       mPending  = 1'b0;

    function automatic logic getRaw(input int btn, input int c);
        if (c < 0) return 1'b0;
        return (btn == 1) ? rawA[c % HIST] : rawW[c % HIST];
    endfunction

    // A button level is accepted once the raw input, seen through the two
    // synchronizer stages, has held the new value for DEBOUNCE_CYCLES cycles.
    function automatic logic stableAt(input int btn, input int k, input logic v);
        for (int i = k - 2 - DEBOUNCE_CYCLES; i <= k - 3; i++) begin
            if (getRaw(btn, i) != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] hexOf(input logic [3:0] code);
        if (code < 4'd10) return 8'd48 + {4'd0, code};
        return 8'd65 + {4'd0, code} - 8'd10;
    endfunction

    function automatic logic modelOut(input int c);
        int n;
        if (mInFrame && c >= mStart && c < mStart + FRAME) begin
            n = (c - mStart) / BAUD_DIV;
            if (n == 0) return 1'b0;
            if (n == 9) return 1'b1;
            return mChar[n - 1];
        end
        return 1'b1;
    endfunction

    always @(negedge sysclk) begin : modelCompare
        int   c;
        logic wRise, aRise, req, expOut;
        c = cyc;
        if (rst) begin
            rawW[c % HIST]  = 1'b0;
            rawA[c % HIST]  = 1'b0;
            rawSw[c % HIST] = 4'd0;
            mWriteDeb = 1'b0;
            mAutoDeb  = 1'b0;
            mInFrame  = 1'b0;
            mPending  = 1'b0;
            expOut    = 1'b1;
        end else begin
            rawW[c % HIST]  = btnWrite;
            rawA[c % HIST]  = btnAuto;
            rawSw[c % HIST] = {sw4, sw3, sw2, sw1};
            wRise = 1'b0;
            aRise = 1'b0;
            if (stableAt(0, c, !mWriteDeb)) begin
                mWriteDeb = !mWriteDeb;
                wRise     = mWriteDeb;
            end
            if (stableAt(1, c, !mAutoDeb)) begin
                mAutoDeb = !mAutoDeb;
                aRise    = mAutoDeb;
            end
            req = wRise;
            if (mAutoDeb && (aRise || (c - mAutoLast == AUTO_PERIOD))) begin
                req       = 1'b1;
                mAutoLast = c;
            end
            expOut = modelOut(c);
            if (!(mInFrame && c >= mStart && c < mStart + FRAME)) begin
                if (mPending || req) begin
                    mInFrame = 1'b1;
                    mStart   = c + 1;
                    mChar    = hexOf((c >= 1) ? rawSw[(c - 1) % HIST] : 4'd0);
                    mPending = 1'b0;
                end
            end else if (req) begin
                mPending = 1'b1;
            end
        end
        checkOutput("line", int'(out), int'(expOut));
    end

    // ---------------- line receiver ----------------
    logic [7:0] rxQ[$];
    int         rxStartQ[$];
    logic       rxStopQ[$];
    logic       rxActive = 1'b0;
    logic       prevOut  = 1'b1;
    int         rxStart  = 0;
    logic [7:0] rxByte   = 8'h00;

    always @(negedge sysclk) begin : rxMonitor
        int off, bitN;
        if (rst) begin
            rxActive = 1'b0;
            prevOut  = 1'b1;
        end else begin
            if (!rxActive && prevOut && !out) begin
                rxActive = 1'b1;
                rxStart  = cyc;
            end
            if (rxActive) begin
                off = cyc - rxStart;
                if (off % BAUD_DIV == BAUD_DIV / 2) begin
                    bitN = off / BAUD_DIV;
                    if (bitN >= 1 && bitN <= 8) begin
                        rxByte[bitN - 1] = out;
                    end else if (bitN == 9) begin
                        rxQ.push_back(rxByte);
                        rxStartQ.push_back(rxStart);
                        rxStopQ.push_back(out);
                        rxActive = 1'b0;
                    end
                end
            end
            prevOut = out;
        end
    end

    task automatic clearRx();
        rxQ.delete();
        rxStartQ.delete();
        rxStopQ.delete();
    endtask

    task automatic checkFrames(input string name, input int expCount, input int pressCyc,
                               input logic [7:0] expChar, input int firstOff, input int spacing);
        checkOutput($sformatf("%s count", name), rxQ.size(), expCount);
        for (int i = 0; i < expCount && i < rxQ.size(); i++) begin
            checkOutput($sformatf("%s char%0d", name, i), int'(rxQ[i]), int'(expChar));
            checkOutput($sformatf("%s start%0d", name, i), rxStartQ[i] - pressCyc, firstOff + i * spacing);
            checkOutput($sformatf("%s stop%0d", name, i), int'(rxStopQ[i]), 1);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stimulus
        int p;
        rst = 1'b1;
        {sw4, sw3, sw2, sw1} = 4'd0;
        btnWrite = 1'b0;
        btnAuto  = 1'b0;
        #1;
        checkOutput("resetLine", int'(out), 1);
        repeat (3) begin
            @(posedge sysclk);
            #1;
        end
        rst = 1'b0;
        checkOutput("afterResetLine", int'(out), 1);
        applyStimulus(1'b0, 1'b0, 4'd0, 20);

        $display("[TB] single write, code 1");
        clearRx();
        p = cyc;
        applyStimulus(1'b1, 1'b0, 4'd1, 40);
        applyStimulus(1'b0, 1'b0, 4'd1, 60);
        checkFrames("single", 1, p, 8'h31, 11, 0);

        $display("[TB] hex letter, switches changed mid-frame");
        clearRx();
        p = cyc;
        applyStimulus(1'b1, 1'b0, 4'hA, 20);
        applyStimulus(1'b0, 1'b0, 4'h2, 80);
        checkFrames("letter", 1, p, 8'h41, 11, 0);

        $display("[TB] bounce rejection");
        clearRx();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd3, 3);
            applyStimulus(1'b0, 1'b0, 4'd3, 3);
        end
        applyStimulus(1'b0, 1'b0, 4'd3, 40);
        checkOutput("bounceOnly count", rxQ.size(), 0);
        clearRx();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd3, 3);
            applyStimulus(1'b0, 1'b0, 4'd3, 3);
        end
        p = cyc;
        applyStimulus(1'b1, 1'b0, 4'd3, 20);
        applyStimulus(1'b0, 1'b0, 4'd3, 60);
        checkFrames("bounceThenHold", 1, p, 8'h33, 11, 0);

        $display("[TB] auto repeat, code F");
        clearRx();
        p = cyc;
        applyStimulus(1'b0, 1'b1, 4'hF, 200);
        applyStimulus(1'b0, 1'b0, 4'hF, 120);
        checkFrames("auto", 4, p, 8'h46, 11, 60);

        $display("[TB] simultaneous write and auto");
        clearRx();
        p = cyc;
        applyStimulus(1'b1, 1'b1, 4'd5, 12);
        applyStimulus(1'b0, 1'b0, 4'd5, 70);
        checkFrames("simultaneous", 1, p, 8'h35, 11, 0);

        $display("[TB] pending entry and dropped request");
        clearRx();
        p = cyc;
        applyStimulus(1'b1, 1'b0, 4'd7, 10);
        applyStimulus(1'b0, 1'b0, 4'd7, 9);
        applyStimulus(1'b1, 1'b0, 4'd7, 10);
        applyStimulus(1'b0, 1'b0, 4'd7, 9);
        applyStimulus(1'b1, 1'b0, 4'd7, 10);
        applyStimulus(1'b0, 1'b0, 4'd7, 120);
        checkFrames("pending", 2, p, 8'h37, 11, FRAME + 1);

        $display("[TB] reset mid-frame");
        clearRx();
        p = cyc;
        applyStimulus(1'b1, 1'b0, 4'd9, 10);
        applyStimulus(1'b0, 1'b0, 4'd9, 10);
        checkOutput("preResetLine", int'(out), 0);
        rst = 1'b1;
        #1;
        checkOutput("midFrameResetLine", int'(out), 1);
        repeat (3) begin
            @(posedge sysclk);
            #1;
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd9, 80);
        checkOutput("postReset count", rxQ.size(), 0);
        clearRx();
        p = cyc;
        applyStimulus(1'b1, 1'b0, 4'd9, 20);
        applyStimulus(1'b0, 1'b0, 4'd9, 60);
        checkFrames("afterReset", 1, p, 8'h39, 11, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
